// File: rtl/ls_unit_if.sv
// ============================================================================
// Module      : ls_unit_if
// Description : Word-addressed data-memory request/acknowledge bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ls_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/ls_unit.sv
// ============================================================================
// Module      : ls_unit
// Description : Load/store sequencer with timeout-bounded memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ls_unit #(
    parameter int TIMEOUT = 15
) (
    input  wire logic        clk,
    input  wire logic        rst_f,
    input  wire logic        start,
    input  wire logic        is_store,
    input  wire logic [31:0] base,
    input  wire logic [15:0] offset,
    input  wire logic [31:0] st_data,
    ls_unit_if.master        mem,
    output logic      [31:0] ld_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] ld_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [15:0] addr_d;
    logic        unused_base_hi;

    // Effective address is 16-bit modular; the carry out is intentionally lost.
    assign addr_d         = base[15:0] + offset;
    assign unused_base_hi = ^base[31:16];

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 32'd0;
            ld_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (start) begin
                        addr_q  <= addr_d;
                        we_q    <= is_store;
                        wdata_q <= st_data;
                        cnt_q   <= 8'd0;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Ack is checked first so an ack on the final cycle still succeeds.
                    if (mem.mem_ack) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (!we_q) begin
                            ld_q <= mem.mem_rdata;
                        end
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == C_LAST) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign ld_data       = ld_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

`default_nettype wire
